// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RISC-V pipeline constants. The decode stage and the write-back unit
// both import this package, so the result-select encoding and the load
// funct3 codes have exactly one definition.
//
// Contents:
//   wb_sel_e      write-back result select (ALU / load / PC+4 / immediate)
//   F3_*          load funct3 codes (LB, LH, LW, LBU, LHU)
// ---------------------------------------------------------------------------
package riscv_pkg;

  // Result select carried down the pipe from decode to write-back.
  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_IMM  = 2'b11
  } wb_sel_e;

  // Load size/sign encodings from the funct3 field.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/write_back_unit_if.sv
// ---------------------------------------------------------------------------
// write_back_unit_if
// Bundle of the MEM-stage outputs that feed the MEM/WB pipeline register.
//
// Signals:
//   mem_valid       MEM stage holds a valid instruction
//   mem_RegWrite    instruction writes rd
//   mem_wb_sel      result select (see riscv_pkg::wb_sel_e)
//   mem_funct3      load size/sign
//   mem_alu_result  ALU result, bits [1:0] double as the load byte offset
//   mem_read_data   raw aligned memory word
//   mem_pc_plus4    link value
//   mem_imm         immediate (e.g. LUI)
//   mem_rd          destination register
//
// Modports: master = MEM stage (drives), slave = write-back unit (samples).
// ---------------------------------------------------------------------------
interface write_back_unit_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);

  logic            mem_valid;
  logic            mem_RegWrite;
  logic [1:0]      mem_wb_sel;
  logic [2:0]      mem_funct3;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_read_data;
  logic [XLEN-1:0] mem_pc_plus4;
  logic [XLEN-1:0] mem_imm;
  logic [RA_W-1:0] mem_rd;

  modport master (
    output mem_valid, mem_RegWrite, mem_wb_sel, mem_funct3,
           mem_alu_result, mem_read_data, mem_pc_plus4, mem_imm, mem_rd
  );

  modport slave (
    input  mem_valid, mem_RegWrite, mem_wb_sel, mem_funct3,
           mem_alu_result, mem_read_data, mem_pc_plus4, mem_imm, mem_rd
  );

endinterface

// File: rtl/load_formatter.sv
// ---------------------------------------------------------------------------
// load_formatter
// Purely combinational load data extraction: picks the addressed byte or
// halfword out of an aligned memory word and sign- or zero-extends it.
//
// Ports:
//   i_funct3  in  3     load size/sign code (riscv_pkg::F3_*)
//   i_offset  in  2     byte offset within the word
//   i_word    in  XLEN  raw aligned memory word
//   o_data    out XLEN  formatted load result
// ---------------------------------------------------------------------------
module load_formatter #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_word,
  output logic [XLEN-1:0] o_data
);

  import riscv_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection. Halfwords only look at offset bit 1, so a misaligned
  // halfword offset silently falls back to its aligned half.
  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extension by load type. LW and any code that is not a load size pass
  // the raw word through untouched.
  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      F3_LW:   o_data = i_word;
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/write_back_unit.sv
// ---------------------------------------------------------------------------
// write_back_unit
// MEM/WB pipeline register plus write-back result selection for a RISC-V
// pipeline. Drives the register-file write port, the forwarding source and
// a per-cycle retire pulse.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   mem_if         in   write_back_unit_if.slave, MEM-stage fields
//   wb_stall       in   hold the WB register
//   wb_flush       in   invalidate the WB register (beats wb_stall)
//   write_value    out  register-file write data
//   out_reg_write  out  register-file write enable (never for x0)
//   out_rd         out  register-file write address
//   fwd_valid      out  forwarding source valid (= out_reg_write)
//   fwd_data       out  forwarding data (= write_value)
//   retire_pulse   out  one instruction leaves WB this cycle
//   retire_count   out  64-bit retired-instruction counter, present only
//                       when WB_RETIRE_CNT_EN is defined
//
// Optional feature macro: WB_RETIRE_CNT_EN
// ---------------------------------------------------------------------------
module write_back_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  write_back_unit_if.slave mem_if,
  input  logic            wb_stall,
  input  logic            wb_flush,
  output logic [XLEN-1:0] write_value,
  output logic            out_reg_write,
  output logic [RA_W-1:0] out_rd,
  output logic            fwd_valid,
  output logic [XLEN-1:0] fwd_data,
  output logic            retire_pulse
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_count
`endif
);

  logic            r_valid;
  logic            r_regWrite;
  wb_sel_e         r_wbSel;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_aluResult;
  logic [XLEN-1:0] r_readData;
  logic [XLEN-1:0] r_pcPlus4;
  logic [XLEN-1:0] r_imm;
  logic [RA_W-1:0] r_rd;

  logic [XLEN-1:0] w_loadData;

  // MEM/WB register. Reset clears everything; a flush only drops the valid
  // bit (the stale fields are harmless once invalid) and wins over a stall
  // so a squashed instruction can never get stuck in WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_regWrite  <= 1'b0;
      r_wbSel     <= WB_SEL_ALU;
      r_funct3    <= '0;
      r_aluResult <= '0;
      r_readData  <= '0;
      r_pcPlus4   <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
    end else if (wb_flush) begin
      r_valid     <= 1'b0;
    end else if (!wb_stall) begin
      r_valid     <= mem_if.mem_valid;
      r_regWrite  <= mem_if.mem_RegWrite;
      r_wbSel     <= wb_sel_e'(mem_if.mem_wb_sel);
      r_funct3    <= mem_if.mem_funct3;
      r_aluResult <= mem_if.mem_alu_result;
      r_readData  <= mem_if.mem_read_data;
      r_pcPlus4   <= mem_if.mem_pc_plus4;
      r_imm       <= mem_if.mem_imm;
      r_rd        <= mem_if.mem_rd;
    end
  end

  // The ALU result's low two bits are the load address offset.
  load_formatter #(
    .XLEN(XLEN)
  ) u_loadFormatter (
    .i_funct3 (r_funct3),
    .i_offset (r_aluResult[1:0]),
    .i_word   (r_readData),
    .o_data   (w_loadData)
  );

  // Result mux, fed only from registered fields so it stays put during a
  // stall no matter what the MEM stage does upstream.
  always_comb begin
    write_value = r_aluResult;
    case (r_wbSel)
      WB_SEL_ALU:  write_value = r_aluResult;
      WB_SEL_LOAD: write_value = w_loadData;
      WB_SEL_PC4:  write_value = r_pcPlus4;
      WB_SEL_IMM:  write_value = r_imm;
      default:     write_value = r_aluResult;
    endcase
  end

  // x0 is hard-wired to zero, so a write to it is suppressed here rather
  // than relying on the register file. Retirement ignores RegWrite: stores
  // and branches retire too, but only once they actually leave WB.
  assign out_reg_write = r_valid & r_regWrite & (r_rd != '0);
  assign out_rd        = r_rd;
  assign fwd_valid     = out_reg_write;
  assign fwd_data      = write_value;
  assign retire_pulse  = r_valid & ~wb_stall;

`ifdef WB_RETIRE_CNT_EN
  // Free-running retired-instruction counter; wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count <= '0;
    end else if (retire_pulse) begin
      retire_count <= retire_count + 64'd1;
    end
  end
`endif

endmodule

// File: doc/write_back_unit.md
WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data path width.
REQ-002 SHALL have parameter RA_W, default 5, register address width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_RegWrite  in  1  instruction writes rd.
- mem_wb_sel  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
- mem_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_alu_result  in  XLEN  ALU result; bits [1:0] are the load byte offset.
- mem_read_data  in  XLEN  raw aligned memory word.
- mem_pc_plus4  in  XLEN  link value.
- mem_imm  in  XLEN  immediate, e.g. LUI.
- mem_rd  in  RA_W  destination register.
- wb_stall  in  1  hold the WB register.
- wb_flush  in  1  invalidate the WB register.
- write_value  out  XLEN  register-file write data.
- out_reg_write  out  1  register-file write enable.
- out_rd  out  RA_W  register-file write address.
- fwd_valid  out  1  forwarding source valid; equals out_reg_write.
- fwd_data  out  XLEN  forwarding data; equals write_value.
- retire_pulse  out  1  one instruction retired this cycle.

Function
REQ-005 SHALL register all mem_* inputs into a single MEM/WB pipeline register with a valid bit.
- Capture-to-output latency: one cycle.
REQ-006 SHALL, per clock edge, apply priority rst > wb_flush > wb_stall > capture.
- rst or wb_flush: valid cleared.
- wb_stall: all fields held.
- Otherwise: load all fields; valid loads mem_valid.
REQ-007 SHALL, with wb_flush and wb_stall both high, clear valid (flush wins).
REQ-008 SHALL derive write_value combinationally from the registered fields per wb_sel.
- Load path: select byte[offset] or halfword[offset[1]]; ignore offset bit 0 for halfwords; ignore the offset for LW.
- LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
- Unlisted funct3 values pass the raw word.
REQ-009 SHALL drive out_reg_write = valid & RegWrite & (rd != 0); register 0 is never written.
REQ-010 SHALL drive out_rd from the registered rd regardless of enable.
REQ-011 SHALL drive retire_pulse = valid & ~wb_stall, independent of RegWrite.
- A stalled instruction retires only on the cycle it leaves WB.
REQ-012 SHALL keep all outputs stable while wb_stall is high.

Reset
REQ-013 SHALL, on rst, clear valid and every registered field to 0.
- Outputs after reset: write_value = 0 (ALU select of 0), out_reg_write = 0, out_rd = 0, fwd_valid = 0, retire_pulse = 0.
REQ-014 SHALL discard an in-flight instruction when rst is asserted mid-operation; no write occurs in the cycle after.

Configuration
REQ-015 SHALL compile a retired-instruction counter when macro WB_RETIRE_CNT_EN is defined.
- Adds output retire_count, 64 bits, reset to 0.
- Increments by 1 on each retire_pulse.
- Wraps from all-ones to 0.
REQ-016 SHALL, without WB_RETIRE_CNT_EN, omit retire_count and its logic entirely; all other behaviour is identical.

Structure
REQ-017 SHALL take the wb_sel encodings and load funct3 codes from shared package riscv_pkg; the same constants are used by decode.
REQ-018 SHALL place load extraction and extension in sub-module load_formatter, purely combinational (inputs funct3, offset, word; output XLEN data).

Verification
REQ-019 Directed scenarios:
- LB, offset 3, word 0x80AA_BBCC, wb_sel 01, rd 5 -> next cycle: write_value 0xFFFF_FF80, out_reg_write 1, out_rd 5.
- LHU, offset 2, word 0x8001_1234 -> write_value 0x0000_8001; LH on the same data -> 0xFFFF_8001.
- ADD to rd 0 with RegWrite 1, ALU 0x1234 -> out_reg_write 0, retire_pulse 1.
- wb_stall high 3 cycles with new mem_* inputs changing -> outputs held; retire_pulse 0 until the stall drops.
- wb_flush and wb_stall high together while valid -> next cycle out_reg_write 0, retire_pulse 0.
- With WB_RETIRE_CNT_EN: 10 valid unstalled instructions, then rst -> retire_count reads 10, then 0 one cycle after rst.
